// File: rtl/rmii_tx_driver_if.sv
`default_nettype none
// =====================================================================
// rmii_tx_driver_if : payload dibit stream (valid/ready) into the RMII TX driver
// Revision: 1.0
// =====================================================================
interface rmii_tx_driver_if;
    logic [1:0] in;
    logic       in_valid;
    logic       in_last;
    logic       in_ready;

    modport master (
        output in,
        output in_valid,
        output in_last,
        input  in_ready
    );

    modport slave (
        input  in,
        input  in_valid,
        input  in_last,
        output in_ready
    );
endinterface
`default_nettype wire

// File: rtl/rmii_tx_driver.sv
`default_nettype none
// =====================================================================
// rmii_tx_driver : RMII transmit driver - preamble/SFD, payload, IFG.
// Optional CRC-32 FCS append when RMII_TX_FCS_EN is defined.
// Revision: 1.0
// =====================================================================
module rmii_tx_driver #(
    parameter int IFG_DIBITS      = 48,
    parameter int PREAMBLE_DIBITS = 31
) (
    input  logic            clk,
    input  logic            rstn,
    rmii_tx_driver_if.slave tx_if,
    output logic            txen,
    output logic [1:0]      txd,
    output logic            busy,
    output logic            underrun
);
    localparam logic [5:0] C_PRE_LAST = 6'(PREAMBLE_DIBITS);
    localparam logic [5:0] C_IFG_LAST = 6'(IFG_DIBITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_DATA     = 3'd2,
`ifdef RMII_TX_FCS_EN
        ST_FCS      = 3'd3,
`endif
        ST_IFG      = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic [5:0] cnt_q, cnt_d;
    logic       txen_q, txen_d;
    logic [1:0] txd_q, txd_d;
    logic       underrun_q, underrun_d;
    logic       start_frame;

`ifdef RMII_TX_FCS_EN
    localparam logic [31:0] C_CRC_POLY = 32'hEDB88320;
    localparam logic [5:0]  C_FCS_LAST = 6'd15;

    logic [31:0] crc_q, crc_d;

    // Reflected CRC-32, two bits per dibit, d[0] enters first.
    function automatic logic [31:0] crc_dibit(input logic [31:0] c, input logic [1:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 2; i++) begin
            r = (r >> 1) ^ (((r[0] ^ d[i]) == 1'b1) ? C_CRC_POLY : 32'd0);
        end
        return r;
    endfunction
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        txen_d      = txen_q;
        txd_d       = txd_q;
        underrun_d  = 1'b0;
        start_frame = 1'b0;
`ifdef RMII_TX_FCS_EN
        crc_d       = crc_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (tx_if.in_valid) start_frame = 1'b1;
            end
            ST_PREAMBLE: begin
                if (cnt_q == C_PRE_LAST) begin
                    txd_d   = 2'b11;
                    state_d = ST_DATA;
                end else begin
                    txd_d = 2'b01;
                    cnt_d = cnt_q + 6'd1;
                end
            end
            ST_DATA: begin
                if (tx_if.in_valid) begin
                    txd_d = tx_if.in;
`ifdef RMII_TX_FCS_EN
                    crc_d = crc_dibit(crc_q, tx_if.in);
`endif
                    if (tx_if.in_last) begin
                        cnt_d = 6'd0;
`ifdef RMII_TX_FCS_EN
                        state_d = ST_FCS;
`else
                        state_d = ST_IFG;
`endif
                    end
                end else begin
                    txen_d     = 1'b0;
                    txd_d      = 2'b00;
                    underrun_d = 1'b1;
                    cnt_d      = 6'd0;
                    state_d    = ST_IFG;
                end
            end
`ifdef RMII_TX_FCS_EN
            ST_FCS: begin
                txd_d = ~crc_q[1:0];
                crc_d = {2'b00, crc_q[31:2]};
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == C_FCS_LAST) begin
                    cnt_d   = 6'd0;
                    state_d = ST_IFG;
                end
            end
`endif
            ST_IFG: begin
                // txen still high means the last dibit is on the wire; the gap starts now.
                if (txen_q) begin
                    txen_d = 1'b0;
                    txd_d  = 2'b00;
                    cnt_d  = 6'd0;
                end else if (cnt_q == C_IFG_LAST) begin
                    // A pending frame starts here so txen stays low exactly IFG_DIBITS cycles.
                    if (tx_if.in_valid) start_frame = 1'b1;
                    else                state_d     = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                txen_d  = 1'b0;
                txd_d   = 2'b00;
                cnt_d   = 6'd0;
            end
        endcase

        if (start_frame) begin
            state_d = ST_PREAMBLE;
            txen_d  = 1'b1;
            txd_d   = 2'b01;
            cnt_d   = 6'd1;
`ifdef RMII_TX_FCS_EN
            crc_d   = '1;
`endif
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 6'd0;
            txen_q     <= 1'b0;
            txd_q      <= 2'b00;
            underrun_q <= 1'b0;
`ifdef RMII_TX_FCS_EN
            crc_q      <= '1;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            txen_q     <= txen_d;
            txd_q      <= txd_d;
            underrun_q <= underrun_d;
`ifdef RMII_TX_FCS_EN
            crc_q      <= crc_d;
`endif
        end
    end

    assign tx_if.in_ready = (state_q == ST_DATA);
    assign txen           = txen_q;
    assign txd            = txd_q;
    assign busy           = (state_q != ST_IDLE);
    assign underrun       = underrun_q;

endmodule
`default_nettype wire
